// File: rtl/tetris_pkg.sv
// Shared types for the falling-block game: block codes, controller states,
// move types and the piece-generator seed.
package tetris_pkg;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        BLK_I = 3'd0,
        BLK_O = 3'd1,
        BLK_T = 3'd2,
        BLK_S = 3'd3,
        BLK_Z = 3'd4,
        BLK_J = 3'd5,
        BLK_L = 3'd6
    } block_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SPAWN = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_LOCK  = 3'd4,
        ST_OVER  = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        MV_SPAWN = 3'd0,
        MV_DOWN  = 3'd1,
        MV_LEFT  = 3'd2,
        MV_RIGHT = 3'd3,
        MV_ROT   = 3'd4
    } move_e;

    // Raw value 7 has no block; fold it onto I so every code is legal.
    function automatic logic [2:0] code_of(input logic [2:0] raw);
        return (raw == 3'd7) ? 3'(BLK_I) : raw;
    endfunction

endpackage

// File: rtl/piece_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) that supplies the
// code of the next piece to spawn.
module piece_lfsr
    import tetris_pkg::*;
(
    input  logic       pclk,
    input  logic       rst_n,
    output logic [2:0] code
);

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= lfsr_d;
    end

    assign code = code_of(lfsr_q[2:0]);

endmodule

// File: rtl/piece_ctrl.sv
// Falling-piece controller: spawn, gravity, player moves via a collision-check
// handshake, and lock. Hard drop is built in when PIECE_CTRL_HARD_DROP_EN is defined.
module piece_ctrl
    import tetris_pkg::*;
#(
    parameter int GRAVITY_FRAMES = 30,
    parameter int SPAWN_COL      = 3
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_rot,
    input  logic        btn_drop,
    output logic        chk_req,
    output logic [11:0] chk_xpos,
    output logic [11:0] chk_ypos,
    output logic [2:0]  chk_block,
    output logic [2:0]  chk_rot,
    input  logic        chk_ack,
    input  logic        chk_hit,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic [2:0]  block,
    output logic [2:0]  rot,
    output logic        lock_stb,
    output logic        game_over
);

    localparam logic [15:0] GRAV_LAST = 16'(GRAVITY_FRAMES - 1);

    state_e      state_q, state_d;
    move_e       move_q, move_d;
    logic        chk_req_q, chk_req_d;
    logic [11:0] cx_q, cx_d, cy_q, cy_d, x_q, x_d, y_q, y_d;
    logic [2:0]  cblk_q, cblk_d, crot_q, crot_d, blk_q, blk_d, rot_q, rot_d;
    logic        lock_q, lock_d, over_q, over_d;
    logic [15:0] grav_cnt_q, grav_cnt_d;
    logic        grav_pend_q, grav_pend_d;
    logic [2:0]  btn_prev_q, btn_prev_d, btn_rise;
    logic        tick_wrap, down_now, pend_take;
    logic [2:0]  next_code;
`ifdef PIECE_CTRL_HARD_DROP_EN
    logic        drop_q, drop_d, drop_prev_q, drop_prev_d, drop_rise;
`else
    logic        unused_drop;
    assign unused_drop = btn_drop;
`endif

    piece_lfsr u_lfsr (
        .pclk  (pclk),
        .rst_n (rst_n),
        .code  (next_code)
    );

    always_comb begin
        state_d    = state_q;
        move_d     = move_q;
        chk_req_d  = chk_req_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        cblk_d     = cblk_q;
        crot_d     = crot_q;
        x_d        = x_q;
        y_d        = y_q;
        blk_d      = blk_q;
        rot_d      = rot_q;
        lock_d     = 1'b0;
        over_d     = over_q;
        grav_cnt_d = grav_cnt_q;
        tick_wrap  = 1'b0;
        // Bit order {rot, left, right} doubles as move priority.
        btn_prev_d = {btn_rot, btn_left, btn_right};
        btn_rise   = btn_prev_d & ~btn_prev_q;

        if (frame_tick && state_q != ST_IDLE && state_q != ST_OVER) begin
            if (grav_cnt_q == GRAV_LAST) begin
                grav_cnt_d = '0;
                tick_wrap  = 1'b1;
            end else begin
                grav_cnt_d = grav_cnt_q + 16'd1;
            end
        end
        grav_pend_d = grav_pend_q | tick_wrap;

`ifdef PIECE_CTRL_HARD_DROP_EN
        drop_d      = drop_q;
        drop_prev_d = btn_drop;
        drop_rise   = btn_drop & ~drop_prev_q;
        down_now    = drop_q | grav_pend_q | drop_rise;
        pend_take   = grav_pend_q & ~drop_q;
`else
        down_now    = grav_pend_q;
        pend_take   = grav_pend_q;
`endif

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d     = ST_SPAWN;
                    over_d      = 1'b0;
                    grav_cnt_d  = '0;
                    grav_pend_d = 1'b0;
                end
            end
            ST_SPAWN: begin
                blk_d     = next_code;
                rot_d     = 3'd0;
                x_d       = 12'(SPAWN_COL);
                y_d       = 12'd0;
                cblk_d    = next_code;
                crot_d    = 3'd0;
                cx_d      = 12'(SPAWN_COL);
                cy_d      = 12'd0;
                move_d    = MV_SPAWN;
                chk_req_d = 1'b1;
                state_d   = ST_CHECK;
            end
            ST_WAIT: begin
                cx_d      = x_q;
                cy_d      = y_q;
                cblk_d    = blk_q;
                crot_d    = rot_q;
                chk_req_d = 1'b1;
                state_d   = ST_CHECK;
                if (down_now) begin
                    move_d = MV_DOWN;
                    cy_d   = y_q + 12'd1;
                    if (pend_take) grav_pend_d = tick_wrap;
`ifdef PIECE_CTRL_HARD_DROP_EN
                    drop_d = drop_q | drop_rise;
`endif
                end else if (btn_rise[2]) begin
                    move_d = MV_ROT;
                    crot_d = {1'b0, rot_q[1:0] + 2'd1};
                end else if (btn_rise[1]) begin
                    move_d = MV_LEFT;
                    cx_d   = x_q - 12'd1;
                end else if (btn_rise[0]) begin
                    move_d = MV_RIGHT;
                    cx_d   = x_q + 12'd1;
                end else begin
                    chk_req_d = 1'b0;
                    state_d   = ST_WAIT;
                end
            end
            ST_CHECK: begin
                if (chk_ack) begin
                    chk_req_d = 1'b0;
                    if (!chk_hit) begin
                        x_d     = cx_q;
                        y_d     = cy_q;
                        blk_d   = cblk_q;
                        rot_d   = crot_q;
                        state_d = ST_WAIT;
                    end else if (move_q == MV_SPAWN) begin
                        over_d  = 1'b1;
                        state_d = ST_OVER;
                    end else if (move_q == MV_DOWN) begin
                        lock_d  = 1'b1;
                        state_d = ST_LOCK;
`ifdef PIECE_CTRL_HARD_DROP_EN
                        drop_d  = 1'b0;
`endif
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_LOCK:  state_d = ST_SPAWN;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            move_q      <= MV_SPAWN;
            chk_req_q   <= 1'b0;
            cx_q        <= '0;
            cy_q        <= '0;
            cblk_q      <= '0;
            crot_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            blk_q       <= '0;
            rot_q       <= '0;
            lock_q      <= 1'b0;
            over_q      <= 1'b0;
            grav_cnt_q  <= '0;
            grav_pend_q <= 1'b0;
            btn_prev_q  <= '0;
`ifdef PIECE_CTRL_HARD_DROP_EN
            drop_q      <= 1'b0;
            drop_prev_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            move_q      <= move_d;
            chk_req_q   <= chk_req_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            cblk_q      <= cblk_d;
            crot_q      <= crot_d;
            x_q         <= x_d;
            y_q         <= y_d;
            blk_q       <= blk_d;
            rot_q       <= rot_d;
            lock_q      <= lock_d;
            over_q      <= over_d;
            grav_cnt_q  <= grav_cnt_d;
            grav_pend_q <= grav_pend_d;
            btn_prev_q  <= btn_prev_d;
`ifdef PIECE_CTRL_HARD_DROP_EN
            drop_q      <= drop_d;
            drop_prev_q <= drop_prev_d;
`endif
        end
    end

    assign chk_req   = chk_req_q;
    assign chk_xpos  = cx_q;
    assign chk_ypos  = cy_q;
    assign chk_block = cblk_q;
    assign chk_rot   = crot_q;
    assign xpos      = x_q;
    assign ypos      = y_q;
    assign block     = blk_q;
    assign rot       = rot_q;
    assign lock_stb  = lock_q;
    assign game_over = over_q;

endmodule

// File: tb/tb_piece_ctrl.sv
// Scoreboard bench for piece_ctrl: a reference piece model queues expected
// check requests and lock strobes; a board responder answers the handshake.
module tb_piece_ctrl;

    localparam int GF = 2;
    localparam int K_DOWN = 0, K_LEFT = 1, K_RIGHT = 2, K_ROT = 3, K_SPAWN = 4;

    logic        pclk = 1'b0;
    logic        rst_n, frame_tick, start, btn_left, btn_right, btn_rot, btn_drop;
    logic        chk_ack = 1'b0, chk_hit = 1'b0;
    logic        chk_req, lock_stb, game_over;
    logic [11:0] chk_xpos, chk_ypos, xpos, ypos;
    logic [2:0]  chk_block, chk_rot, block, rot;

    piece_ctrl #(.GRAVITY_FRAMES(GF), .SPAWN_COL(3)) dut (
        .pclk(pclk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start),
        .btn_left(btn_left), .btn_right(btn_right), .btn_rot(btn_rot), .btn_drop(btn_drop),
        .chk_req(chk_req), .chk_xpos(chk_xpos), .chk_ypos(chk_ypos),
        .chk_block(chk_block), .chk_rot(chk_rot), .chk_ack(chk_ack), .chk_hit(chk_hit),
        .xpos(xpos), .ypos(ypos), .block(block), .rot(rot),
        .lock_stb(lock_stb), .game_over(game_over)
    );

    always #5 pclk = ~pclk;

    typedef struct { logic [11:0] x; logic [11:0] y; logic [2:0] r; bit spawn; } req_t;
    typedef struct { logic [11:0] x; logic [11:0] y; } lock_t;
    req_t  exp_q[$];
    lock_t lock_q[$];

    int checks = 0, errors = 0, lock_seen = 0;
    int floor_row = 8, gcnt = 0, fixed_dly = -1, stray_req = 0;
    bit full = 0, m_over = 0, hold_ack = 0;
    logic [11:0] mx = 0, my = 0;
    logic [2:0]  mr = 0;

    // Board: ten columns (0..9), rows 0..floor_row are free.
    function automatic bit board_hit(input logic [11:0] x, input logic [11:0] y);
        return full || (x > 12'd9) || (int'(y) > floor_row);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: apply one move to the model piece and queue what the DUT must show.
    task automatic model_move(input int kind, output bit hit);
        logic [11:0] nx, ny;
        logic [2:0]  nr;
        bit          h2;
        nx = mx; ny = my; nr = mr;
        case (kind)
            K_DOWN:  ny = my + 12'd1;
            K_LEFT:  nx = mx - 12'd1;
            K_RIGHT: nx = mx + 12'd1;
            K_ROT:   nr = 3'((int'(mr) + 1) % 4);
            default: begin nx = 12'd3; ny = 12'd0; nr = 3'd0; end
        endcase
        exp_q.push_back('{nx, ny, nr, kind == K_SPAWN});
        hit = board_hit(nx, ny);
        if (kind == K_SPAWN) begin
            mx = nx; my = ny; mr = nr;
            if (hit) m_over = 1;
        end else if (!hit) begin
            mx = nx; my = ny; mr = nr;
        end else if (kind == K_DOWN) begin
            lock_q.push_back('{mx, my});
            model_move(K_SPAWN, h2);
        end
    endtask

    task automatic press(input bit r, input bit l, input bit rt, input bit d);
        @(negedge pclk);
        btn_rot = r; btn_left = l; btn_right = rt; btn_drop = d;
        @(negedge pclk);
        btn_rot = 0; btn_left = 0; btn_right = 0; btn_drop = 0;
    endtask

    task automatic pulse_start();
        @(negedge pclk); start = 1;
        @(negedge pclk); start = 0;
    endtask

    task automatic start_game();
        bit h;
        m_over = 0;
        model_move(K_SPAWN, h);
        pulse_start();
    endtask

    task automatic tick();
        bit h;
        gcnt++;
        if (gcnt == GF) begin
            gcnt = 0;
            model_move(K_DOWN, h);
        end
        @(negedge pclk); frame_tick = 1;
        @(negedge pclk); frame_tick = 0;
    endtask

    task automatic settle();
        int n = 0;
        @(negedge pclk);
        while ((exp_q.size() != 0 || chk_req) && n < 300) begin
            @(negedge pclk);
            n++;
        end
        if (n >= 300) begin
            checks++; errors++;
            $display("FAIL settle_timeout pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge pclk);
        check("xpos", xpos, mx);
        check("ypos", ypos, my);
        check("rot", rot, mr);
        check("game_over", game_over, m_over);
        check("lock_pending", lock_q.size(), 0);
        lock_q.delete();
    endtask

    task automatic wait_req();
        int n = 0;
        while (!chk_req && n < 50) begin
            @(negedge pclk);
            n++;
        end
        check("req_arrives", chk_req, 1);
    endtask

    // Monitor: compare every new check request and every lock strobe.
    initial begin
        bit prev_req = 0, prev_lock = 0;
        req_t  e;
        lock_t l;
        forever begin
            @(negedge pclk);
            if (chk_req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_req x=%0h y=%0h rot=%0d required=none", chk_xpos, chk_ypos, chk_rot);
                end else begin
                    e = exp_q.pop_front();
                    check("chk_xpos", chk_xpos, e.x);
                    check("chk_ypos", chk_ypos, e.y);
                    check("chk_rot", chk_rot, e.r);
                    if (e.spawn) check("spawn_block_legal", chk_block <= 3'd6, 1);
                end
            end
            if (lock_stb) begin
                lock_seen++;
                if (prev_lock) begin
                    checks++; errors++;
                    $display("FAIL lock_width actual=2+ required=1");
                end else if (lock_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_lock y=%0h required=none", ypos);
                end else begin
                    l = lock_q.pop_front();
                    check("lock_xpos", xpos, l.x);
                    check("lock_ypos", ypos, l.y);
                end
            end
            prev_req  = chk_req;
            prev_lock = lock_stb;
        end
    end

    // Board responder: acks each request after a delay with the board's verdict.
    initial begin
        int cnt = 0, cur_dly = 0, stray_seen = 0;
        forever begin
            @(negedge pclk);
            if (chk_ack) begin
                chk_ack = 0; chk_hit = 0;
            end else if (stray_req != stray_seen) begin
                stray_seen = stray_req;
                chk_ack = 1; chk_hit = 0;
            end else if (chk_req && !hold_ack) begin
                if (cnt == 0) cur_dly = (fixed_dly < 0) ? int'($urandom_range(3, 0)) : fixed_dly;
                if (cnt >= cur_dly) begin
                    chk_ack = 1;
                    chk_hit = board_hit(chk_xpos, chk_ypos);
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit h;
        int locks0;
        rst_n = 0; frame_tick = 0; start = 0;
        btn_left = 0; btn_right = 0; btn_rot = 0; btn_drop = 0;
        repeat (3) @(negedge pclk);
        check("rst_chk_req", chk_req, 0);
        check("rst_xpos", xpos, 0);
        check("rst_ypos", ypos, 0);
        check("rst_block", block, 0);
        check("rst_lock", lock_stb, 0);
        check("rst_over", game_over, 0);
        rst_n = 1;
        @(negedge pclk);

        // Spawn into a full board ends the game without a lock.
        full = 1;
        start_game();
        settle();
        check("over_after_spawn_hit", game_over, 1);
        full = 0;

        // Clean spawn, acked two cycles after the request.
        fixed_dly = 2;
        start_game();
        settle();
        check("spawn_x", xpos, 3);
        check("spawn_y", ypos, 0);
        check("block_legal", block <= 3'd6, 1);
        fixed_dly = -1;

        // Gravity: every second frame tick is one row.
        for (int i = 0; i < 4; i++) begin
            tick();
            settle();
        end
        check("grav_y", ypos, 2);

        // Rotate and left together: rotation wins.
        model_move(K_ROT, h);
        press(1, 1, 0, 0);
        settle();
        check("rot_wins_rot", rot, 1);
        check("rot_wins_x", xpos, 3);

        // Walk into both walls; the wrapped 12'hFFF column is refused by the board.
        for (int i = 0; i < 4; i++) begin model_move(K_LEFT, h); press(0, 1, 0, 0); settle(); end
        check("left_wall_x", xpos, 0);
        for (int i = 0; i < 10; i++) begin model_move(K_RIGHT, h); press(0, 0, 1, 0); settle(); end
        check("right_wall_x", xpos, 9);

        // Floor directly below: next gravity step locks and respawns.
        floor_row = int'(my);
        locks0 = lock_seen;
        tick(); settle();
        tick(); settle();
        check("one_lock", lock_seen - locks0, 1);
        check("respawn_y", ypos, 0);

        // Randomised play.
        floor_row = 6;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(3, 0))
                0: tick();
                1: begin model_move(K_LEFT, h);  press(0, 1, 0, 0); end
                2: begin model_move(K_RIGHT, h); press(0, 0, 1, 0); end
                default: begin model_move(K_ROT, h); press(1, 0, 0, 0); end
            endcase
            settle();
        end

        // Button and start edges while a check is outstanding are dropped.
        hold_ack = 1;
        model_move(K_ROT, h);
        press(1, 0, 0, 0);
        wait_req();
        press(0, 1, 0, 0);
        pulse_start();
        hold_ack = 0;
        settle();
        pulse_start();
        settle();

        // Asynchronous reset in the middle of a check.
        hold_ack = 1;
        model_move(K_ROT, h);
        press(1, 0, 0, 0);
        wait_req();
        #2 rst_n = 0;
        #1;
        check("async_rst_req", chk_req, 0);
        check("async_rst_x", xpos, 0);
        check("async_rst_rot", rot, 0);
        exp_q.delete(); lock_q.delete();
        mx = 0; my = 0; mr = 0; gcnt = 0; m_over = 0;
        hold_ack = 0;
        @(negedge pclk);
        rst_n = 1;
        stray_req++;
        repeat (5) @(negedge pclk);
        check("stray_ack_req", chk_req, 0);
        check("stray_ack_y", ypos, 0);
        check("stray_ack_over", game_over, 0);

        start_game();
        settle();
`ifdef PIECE_CTRL_HARD_DROP_EN
        // Hard drop: rows 1..5 requested, row 5 hits, piece locks at row 4.
        floor_row = 4;
        locks0 = lock_seen;
        h = 0;
        while (!h) model_move(K_DOWN, h);
        press(0, 0, 0, 1);
        settle();
        check("drop_lock", lock_seen - locks0, 1);
        check("drop_respawn_y", ypos, 0);
`else
        // Without hard drop the button has no effect.
        press(0, 0, 0, 1);
        settle();
        check("drop_ignored_y", ypos, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
